// File: rtl/spi_sequence_start_detector_pkg.sv
// Shared constants and FSM encoding for the SPI session-start detector.
// The default magic value is mirrored in the host-side test firmware headers.
package spi_sequence_start_detector_pkg;

  localparam logic [31:0]  SEQUENCE_DEFAULT       = 32'h5A3C_96E1;
  localparam int unsigned  TIMEOUT_CYCLES_DEFAULT = 1024;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    WAIT_LOW = 2'd1,
    PULSE    = 2'd2,
    HOLDOFF  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/spi_sequence_start_detector_edge_sync.sv
// spi_edge_sync: optional 2-flop input sync (SPI_SEQ_DETECT_SYNC_EN), sclk edge
// detection and idle/timeout counting. Shared with the chip-select decoder.
module spi_edge_sync
  import spi_sequence_start_detector_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic sin,
  output logic sin_s,
  output logic sclk_pos,
  output logic sclk_neg,
  output logic timeout
);

  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);

  logic          sclk_s;
  logic          sclk_prev;
  logic [IW-1:0] idle_cnt;

`ifdef SPI_SEQ_DETECT_SYNC_EN
  logic [1:0] sclk_sync;
  logic [1:0] sin_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      sin_sync  <= '0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      sin_sync  <= {sin_sync[0], sin};
    end
  end

  assign sclk_s = sclk_sync[1];
  assign sin_s  = sin_sync[1];
`else
  assign sclk_s = sclk;
  assign sin_s  = sin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev <= 1'b0;
    end else begin
      sclk_prev <= sclk_s;
    end
  end

  assign sclk_pos = sclk_s & ~sclk_prev;
  assign sclk_neg = ~sclk_s & sclk_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (sclk_pos || sclk_neg) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IW'(TIMEOUT_CYCLES)) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  // An edge in the same cycle wins over a saturated idle count.
  assign timeout = (idle_cnt == IW'(TIMEOUT_CYCLES)) && !(sclk_pos || sclk_neg);

endmodule

// File: rtl/spi_sequence_start_detector.sv
// Recognises the magic session-start sequence on sclk/sin and emits a one-clk
// start pulse while sclk is low. Input sync selected by SPI_SEQ_DETECT_SYNC_EN.
module spi_sequence_start_detector
  import spi_sequence_start_detector_pkg::*;
#(
  parameter int unsigned              SEQUENCE_SIZE  = 32,
  parameter logic [SEQUENCE_SIZE-1:0] SEQUENCE       = SEQUENCE_SIZE'(SEQUENCE_DEFAULT),
  parameter int unsigned              HOLDOFF_BITS   = 16,
  parameter int unsigned              TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int unsigned              COUNT_SIZE     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  sin,
  output logic                  start,
  output logic                  busy,
  output logic [COUNT_SIZE-1:0] match_count
);

  localparam int unsigned FW = $clog2(SEQUENCE_SIZE + 1);
  localparam int unsigned HW = (HOLDOFF_BITS < 1) ? 1 : $clog2(HOLDOFF_BITS + 1);

  logic sin_s;
  logic sclk_pos;
  logic sclk_neg;
  logic timeout;

  seq_state_e               state_q, state_d;
  logic [SEQUENCE_SIZE-2:0] shreg_q, shreg_d;
  logic [FW-1:0]            fill_q,  fill_d;
  logic [HW-1:0]            hold_q,  hold_d;
  logic [COUNT_SIZE-1:0]    count_q, count_d;
  logic                     start_q, start_d;
  logic                     match;

  spi_edge_sync #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_edge_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .sin      (sin),
    .sin_s    (sin_s),
    .sclk_pos (sclk_pos),
    .sclk_neg (sclk_neg),
    .timeout  (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      shreg_q <= '0;
      fill_q  <= '0;
      hold_q  <= '0;
      count_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
      count_q <= count_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    fill_d  = fill_q;
    hold_d  = hold_q;
    count_d = count_q;
    start_d = 1'b0;
    // Lookahead: compare with the incoming bit before it lands in the shreg.
    match   = sclk_pos && (fill_q >= FW'(SEQUENCE_SIZE - 1)) &&
              ({shreg_q, sin_s} == SEQUENCE);

    case (state_q)
      HUNT: begin
        if (sclk_pos) begin
          shreg_d = {shreg_q[SEQUENCE_SIZE-3:0], sin_s};
          if (fill_q != FW'(SEQUENCE_SIZE)) begin
            fill_d = fill_q + FW'(1);
          end
          if (match) begin
            state_d = WAIT_LOW;
            count_d = count_q + COUNT_SIZE'(1);
          end
        end
      end
      WAIT_LOW: begin
        if (sclk_neg) begin
          state_d = PULSE;
        end
      end
      PULSE: begin
        start_d = 1'b1;
        hold_d  = HW'(HOLDOFF_BITS);
        if (HOLDOFF_BITS == 0) begin
          shreg_d = '0;
          fill_d  = '0;
          state_d = HUNT;
        end else begin
          state_d = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (sclk_pos) begin
          if (hold_q <= HW'(1)) begin
            hold_d  = '0;
            shreg_d = '0;
            fill_d  = '0;
            state_d = HUNT;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
      end
      default: state_d = HUNT;
    endcase

    if (timeout && (state_q != PULSE)) begin
      state_d = HUNT;
      shreg_d = '0;
      fill_d  = '0;
      hold_d  = '0;
    end
  end

  assign start       = start_q;
  assign busy        = (state_q != HUNT);
  assign match_count = count_q;

endmodule

// File: tb/tb_spi_sequence_start_detector.sv
// Randomised bench for spi_sequence_start_detector against a bit-level model.
// Honours SPI_SEQ_DETECT_SYNC_EN for the expected start latency.
module tb_spi_sequence_start_detector;

  localparam int HALF  = 8;
  localparam int HALF2 = 4;
`ifdef SPI_SEQ_DETECT_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam logic [31:0] SEQ  = 32'h5A3C_96E1;
  localparam logic [7:0]  SEQ2 = 8'hB4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk  = 1'b0;
  logic       sin   = 1'b0;
  logic       start, busy;
  logic [7:0] match_count;
  logic       sclk2 = 1'b0;
  logic       sin2  = 1'b0;
  logic       start2, busy2;
  logic [7:0] match_count2;

  int checks = 0;
  int errors = 0;

  // Reference model: last 32 received bits, how many are valid, bits of holdoff left.
  logic [31:0] m_win  = '0;
  int          m_cnt  = 0;
  int          m_hold = 0;
  logic [7:0]  m_mc   = '0;
  logic [7:0]  m2_win = '0;
  int          m2_cnt = 0;
  logic [7:0]  m2_mc  = '0;

  always #5 clk = ~clk;

  spi_sequence_start_detector #(
    .SEQUENCE_SIZE(32), .SEQUENCE(SEQ), .HOLDOFF_BITS(16),
    .TIMEOUT_CYCLES(1024), .COUNT_SIZE(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .sin(sin),
    .start(start), .busy(busy), .match_count(match_count)
  );

  spi_sequence_start_detector #(
    .SEQUENCE_SIZE(8), .SEQUENCE(SEQ2), .HOLDOFF_BITS(0),
    .TIMEOUT_CYCLES(1024), .COUNT_SIZE(8)
  ) u_dut8 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk2), .sin(sin2),
    .start(start2), .busy(busy2), .match_count(match_count2)
  );

  task automatic model_bit(input logic b, output bit hit);
    hit = 1'b0;
    if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) begin
        m_win = '0;
        m_cnt = 0;
      end
    end else begin
      m_win = {m_win[30:0], b};
      if (m_cnt < 32) m_cnt++;
      hit = (m_cnt == 32) && (m_win == SEQ);
      if (hit) begin
        m_mc   = m_mc + 8'd1;
        m_hold = 16;
      end
    end
  endtask

  // Called and returns at #1 after a clk posedge.
  task automatic send_bit(input logic b, input string tag);
    bit hit;
    int hi_p = 0, lo_p = 0, lo_pos = -1;
    model_bit(b, hit);
    sin = b;
    sclk = 1'b1;
    for (int i = 1; i <= HALF; i++) begin
      @(posedge clk); #1;
      if (start) hi_p++;
    end
    sclk = 1'b0;
    for (int i = 1; i <= HALF; i++) begin
      @(posedge clk); #1;
      if (start) begin
        lo_p++;
        if (lo_pos < 0) lo_pos = i;
      end
    end
    checks++;
    if (hi_p != 0 || lo_p != (hit ? 1 : 0) || (hit && lo_pos != LAT)) begin
      errors++;
      $display("FAIL start_%s: high_phase=%0d low_phase=%0d pos=%0d required high_phase=0 low_phase=%0d pos=%0d",
               tag, hi_p, lo_p, lo_pos, hit ? 1 : 0, hit ? LAT : -1);
    end
    checks++;
    if (busy !== (m_hold > 0)) begin
      errors++;
      $display("FAIL busy_%s: got %b required %b", tag, busy, (m_hold > 0));
    end
    checks++;
    if (match_count !== m_mc) begin
      errors++;
      $display("FAIL match_count_%s: got %0d required %0d", tag, match_count, m_mc);
    end
  endtask

  task automatic send_bits(input logic [31:0] w, input int hi, input int lo, input string tag);
    for (int i = hi; i >= lo; i--) send_bit(w[i], tag);
  endtask

  task automatic flush_holdoff();
    while (m_hold > 0) send_bit(1'($urandom_range(0, 1)), "flush");
  endtask

  task automatic idle(input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (start) seen++;
    end
    if (n >= 1024) begin
      m_win = '0; m_cnt = 0; m_hold = 0;
    end
    checks++;
    if (seen != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle: pulses=%0d busy=%b required pulses=0 busy=0", seen, busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (start !== 1'b0 || busy !== 1'b0 || match_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: start=%b busy=%b count=%0d required 0 0 0", start, busy, match_count);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)), "pre");
    send_bits(SEQ, 31, 0, "single");
    checks++;
    if (match_count !== 8'd1) begin
      errors++;
      $display("FAIL single_count: got %0d required 1", match_count);
    end
  endtask

  task automatic test_holdoff();
    send_bits(SEQ, 31, 0, "embedded");
    for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)), "holdoff");
    send_bits(SEQ, 31, 0, "rearm");
  endtask

  task automatic test_timeout();
    flush_holdoff();
    send_bits(SEQ, 31, 12, "to_head");
    idle(1100);
    send_bits(SEQ, 11, 0, "to_tail");
  endtask

  task automatic test_wrong_last();
    flush_holdoff();
    send_bits(SEQ ^ 32'd1, 31, 0, "wrong");
    send_bits(SEQ, 31, 0, "right");
  endtask

  task automatic test_reset_wait_low();
    bit hit, hit2;
    int seen = 0;
    flush_holdoff();
    send_bits(SEQ, 31, 1, "rst_pre");
    model_bit(SEQ[0], hit);
    sin = SEQ[0];
    sclk = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (busy !== hit) begin
      errors++;
      $display("FAIL busy_wait_low: got %b required %b", busy, hit);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (start !== 1'b0 || busy !== 1'b0 || match_count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: start=%b busy=%b count=%0d required 0 0 0", start, busy, match_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_win = '0; m_cnt = 0; m_hold = 0; m_mc = '0;
    // sclk is still high at release, so the bit is taken as freshly clocked in.
    model_bit(SEQ[0], hit2);
    for (int i = 0; i < HALF - 4; i++) begin @(posedge clk); #1; if (start) seen++; end
    sclk = 1'b0;
    for (int i = 0; i < HALF; i++) begin @(posedge clk); #1; if (start) seen++; end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_pulse: pulses=%0d required 0", seen);
    end
    send_bits(SEQ, 31, 0, "after_rst");
  endtask

  task automatic test_random();
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 9) == 0) send_bits(SEQ, 31, 0, "rnd_seq");
      else send_bit(1'($urandom_range(0, 1)), "rnd");
    end
  endtask

  task automatic send_bit2(input logic b);
    bit hit;
    int p = 0, pos = -1, hi_p = 0;
    m2_win = {m2_win[6:0], b};
    if (m2_cnt < 8) m2_cnt++;
    hit = (m2_cnt == 8) && (m2_win == SEQ2);
    if (hit) begin
      m2_mc = m2_mc + 8'd1;
      m2_win = '0;
      m2_cnt = 0;
    end
    sin2 = b;
    sclk2 = 1'b1;
    for (int i = 1; i <= HALF2; i++) begin @(posedge clk); #1; if (start2) hi_p++; end
    sclk2 = 1'b0;
    for (int i = 1; i <= HALF2; i++) begin
      @(posedge clk); #1;
      if (start2) begin p++; if (pos < 0) pos = i; end
    end
    checks++;
    if (hi_p != 0 || p != (hit ? 1 : 0) || (hit && pos != LAT)) begin
      errors++;
      $display("FAIL b2b_start: high_phase=%0d low_phase=%0d pos=%0d required 0 %0d %0d",
               hi_p, p, pos, hit ? 1 : 0, hit ? LAT : -1);
    end
    checks++;
    if (match_count2 !== m2_mc) begin
      errors++;
      $display("FAIL b2b_count: got %0d required %0d", match_count2, m2_mc);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    w = SEQ2;
    for (int s = 0; s < 256; s++) begin
      for (int i = 7; i >= 0; i--) send_bit2(w[i]);
    end
    checks++;
    if (match_count2 !== 8'd0) begin
      errors++;
      $display("FAIL b2b_wrap: got %0d required 0", match_count2);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_holdoff();
    test_timeout();
    test_wrong_last();
    test_reset_wait_low();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_sequence_start_detector.md
Name: spi_sequence_start_detector

Overview:
- Upstream stage of the SPI chip-select decoder. Watches the raw test-shield SPI lines (sclk, sin) and recognises a fixed magic bit sequence that marks the start of a session.
- Emits a one-clock `start` pulse while sclk is low, so the decoder can begin reading its select and cycles fields on the next sclk rising edge.
- SPI mode 0 only: sin is sampled on sclk rising edges.

Parameters:
- SEQUENCE_SIZE, 32, width of the magic sequence in bits (min 8).
- SEQUENCE, 32'h5A3C_96E1, magic value; MSB is received first.
- HOLDOFF_BITS, 16, sclk rising edges after `start` during which matching is suppressed (covers select + cycles fields).
- TIMEOUT_CYCLES, 1024, clk cycles without any sclk edge before partial state is discarded.
- COUNT_SIZE, 8, width of `match_count`.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sclk  input  1  SPI clock from the DUT.
- sin  input  1  SPI MOSI from the DUT.
- start  output  1  one-clk session-start pulse, asserted only while sclk is low.
- busy  output  1  high in any state other than HUNT.
- match_count  output  COUNT_SIZE  number of sequences detected; wraps on overflow.

Behaviour:
- Reset (asynchronous, rst_n=0) clears every register:
  - start=0, busy=0, match_count=0.
  - Shift register and fill counter cleared; holdoff counter cleared; idle counter cleared.
  - State returns to HUNT.
  - Assertion mid-operation aborts immediately, with no pulse.
- Edge detection uses the effective sclk_s (see the optional feature) against a registered copy sclk_prev.
  - posedge = sclk_s & ~sclk_prev.
  - negedge = ~sclk_s & sclk_prev.
- Timing requirement: sclk high and low phases are each ≥ 4 clk cycles.
- Idle counter:
  - Cleared on any sclk edge; otherwise increments and saturates at TIMEOUT_CYCLES.
  - Reaching TIMEOUT_CYCLES forces the timeout action below.
  - An edge and a timeout cannot coincide; the edge takes priority.
- Shift register (SEQUENCE_SIZE-1 bits) and fill counter (saturating at SEQUENCE_SIZE):
  - On each posedge in HUNT, the shift register takes sin into its LSB and the fill counter increments.
- Match is a lookahead on a HUNT posedge: fill ≥ SEQUENCE_SIZE-1 and {shreg, sin} == SEQUENCE.
- FSM:
  - HUNT: shifting as above. On match → WAIT_LOW; match_count increments in the same cycle.
  - WAIT_LOW: on negedge → PULSE.
  - PULSE: start=1 for exactly this one clk, while sclk is still low. Load holdoff=HOLDOFF_BITS; go to HOLDOFF.
  - HOLDOFF: decrement holdoff on each posedge. When it reaches 0, clear the shift register and fill counter; go to HUNT. With HOLDOFF_BITS=0, go straight to HUNT.
  - Timeout in any state except PULSE: clear shift register, fill counter and holdoff; go to HUNT. No start is produced if the match was still in WAIT_LOW.
- Latency: start rises 2 clk after the sclk falling edge that follows the last sequence bit (+2 with the sync feature).
- A sequence that immediately follows the HOLDOFF_BITS data bits is detected again; this is legal re-arming.

Optional Feature:
- Macro SPI_SEQ_DETECT_SYNC_EN.
- Defined: sclk and sin each pass through a 2-flop synchronizer (reset to 0) before use. All latencies grow by 2 clk.
- Undefined: sclk and sin are used directly, for the case where an external synchronizer is already instantiated.

Decomposition:
- Shared package holds:
  - the default magic SEQUENCE constant, shared with the host-side test firmware headers;
  - the FSM state encoding (HUNT, WAIT_LOW, PULSE, HOLDOFF; 2 bits);
  - the TIMEOUT_CYCLES default.
- One sub-module: spi_edge_sync. It does the optional synchronization, produces posedge/negedge, and runs the idle/timeout counter. It is reusable by the chip-select decoder.

Test Plan:
- Shift 32'h5A3C_96E1 MSB-first, sclk half-period 8 clk → exactly one start pulse 2 clk after the 32nd falling edge, sclk=0 during the pulse; match_count=1; busy high from the match until holdoff ends.
- Send 16 holdoff bits, then 32'h5A3C_96E1 again → second start pulse; match_count=2. If the sequence is embedded inside the 16 holdoff bits → no pulse.
- Send the first 20 bits of the sequence, idle 1100 clk, then the last 12 bits → no start pulse; busy stays 0.
- Send 32'h5A3C_96E0 (last bit wrong), then the correct sequence → exactly one pulse, aligned to the correct sequence only.
- Drop rst_n for 1 clk during WAIT_LOW → no pulse; all outputs 0 asynchronously; the next full sequence is detected normally.
- Run 256 back-to-back sessions → match_count wraps to 0; start pulse width is always 1 clk.
